// File: rtl/bascomp_pkg.sv
// Shared definitions for the basic-computer control path: bus source codes,
// sequencer states and the per-register control strobe bundle.
package bascomp_pkg;

  localparam int ADDR_W = 12;
  localparam int OP_W   = 3;
  localparam int SC_W   = 4;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    T0   = 3'd2,
    T1   = 3'd3,
    T2   = 3'd4,
    T3   = 3'd5,
    EXEC = 3'd6,
    HALT = 3'd7
  } state_e;

  typedef struct packed {
    logic load;
    logic inc;
    logic clr;
  } reg_ctl_t;

  function automatic logic state_busy(input state_e s);
    return !(s inside {IDLE, HALT});
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating timing counter: counts cycles since the last clear and holds at
// its maximum instead of wrapping.
module seq_timer #(
  parameter int SCW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  output logic [SCW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + SCW'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch / decode / indirect sequencer for the basic computer. Drives AR, PC and
// IR strobes plus bus select, then hands off to the execute unit.
module fetch_sequencer
  import bascomp_pkg::*;
#(
  parameter int OPW = OP_W,
  parameter int SCW = SC_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           halt_req,
  input  logic           ir_ind,
  input  logic [OPW-1:0] ir_op,
  input  logic           exec_done,
  input  logic           exec_pc_inc,
  input  logic           exec_pc_load,
  output logic           ar_load,
  output logic           ar_inc,
  output logic           ar_clr,
  output logic           pc_load,
  output logic           pc_inc,
  output logic           pc_clr,
  output logic           ir_load,
  output logic           mem_read,
  output logic [2:0]     bus_sel,
  output logic           exec_start,
  output logic [SCW-1:0] sc,
  output logic           busy
);

  state_e         state;
  state_e         state_nxt;
  logic           in_exec_q;
  logic [SCW-1:0] sc_q;

  reg_ctl_t       ar_ctl;
  reg_ctl_t       pc_ctl;
  logic           ir_ld;
  logic           rd;
  bus_sel_e       bus;
  logic           xs;

  // Register-reference / IO opcode (all ones) never takes the indirect cycle.
  logic           indirect;
  assign indirect = ir_ind && (ir_op != {OPW{1'b1}});

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so state and in_exec_q both sample pre-edge values.
    if (rst) begin
      state     <= IDLE;
      in_exec_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_exec_q <= (state == EXEC);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = CLR;
      CLR:  state_nxt = T0;
      T0:   state_nxt = T1;
      T1:   state_nxt = T2;
      T2:   state_nxt = indirect ? T3 : EXEC;
      T3:   state_nxt = EXEC;
      EXEC: if (exec_done) state_nxt = halt_req ? HALT : T0;
      HALT: if (start) state_nxt = T0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    ar_ctl = '0;
    pc_ctl = '0;
    ir_ld  = 1'b0;
    rd     = 1'b0;
    bus    = BUS_NONE;
    xs     = 1'b0;
    unique case (state)
      CLR: begin
        ar_ctl.clr = 1'b1;
        pc_ctl.clr = 1'b1;
      end
      T0: begin
        bus         = BUS_PC;
        ar_ctl.load = 1'b1;
      end
      T1: begin
        bus        = BUS_MEM;
        rd         = 1'b1;
        ir_ld      = 1'b1;
        pc_ctl.inc = 1'b1;
      end
      T2: begin
        bus         = BUS_IR;
        ar_ctl.load = 1'b1;
      end
      T3: begin
        bus         = BUS_MEM;
        rd          = 1'b1;
        ar_ctl.load = 1'b1;
      end
      EXEC: begin
        // A branch overrides a skip so PC never sees load and inc together.
        xs          = !in_exec_q;
        pc_ctl.load = exec_pc_load;
        pc_ctl.inc  = exec_pc_inc && !exec_pc_load;
      end
      default: ;
    endcase
  end

  // Reset wins combinationally: nothing is strobed while rst is high.
  assign ar_load    = ar_ctl.load && !rst;
  assign ar_inc     = ar_ctl.inc  && !rst;
  assign ar_clr     = ar_ctl.clr  && !rst;
  assign pc_load    = pc_ctl.load && !rst;
  assign pc_inc     = pc_ctl.inc  && !rst;
  assign pc_clr     = pc_ctl.clr  && !rst;
  assign ir_load    = ir_ld && !rst;
  assign mem_read   = rd && !rst;
  assign bus_sel    = rst ? BUS_NONE : bus;
  assign exec_start = xs && !rst;
  assign busy       = state_busy(state) && !rst;
  assign sc         = rst ? '0 : sc_q;

  // The counter restarts whenever the sequence (re)enters T0 or leaves the busy states.
  seq_timer #(.SCW(SCW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_nxt inside {IDLE, CLR, T0, HALT}),
    .count (sc_q)
  );

  ar_excl: assert property (@(posedge clk) $onehot0({ar_load, ar_inc, ar_clr}));
  pc_excl: assert property (@(posedge clk) $onehot0({pc_load, pc_inc, pc_clr}));

endmodule
